// File: rtl/hsv2rgb_pipe.sv
// HSV -> RGB converter: an input register followed by four compute stages
// (hue normalise, products, divide, sector select) sharing one global stall.
module hsv2rgb_pipe #(
  parameter bit HUE_WRAP = 1'b1,
  parameter int TAG_W    = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [8:0]       H_IN,
  input  logic [7:0]       S_IN,
  input  logic [7:0]       V_IN,
  input  logic [TAG_W-1:0] TAG_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [7:0]       R_OUT,
  output logic [7:0]       G_OUT,
  output logic [7:0]       B_OUT,
  output logic [TAG_W-1:0] TAG_OUT
);

  // Bank 0: registered input pixel
  logic             vld0_q, vld0_d;
  logic [8:0]       h0_q, h0_d;
  logic [7:0]       sat0_q, sat0_d;
  logic [7:0]       v0_q, v0_d;
  logic [TAG_W-1:0] tag0_q, tag0_d;

  // Bank 1: sector and scaled fraction
  logic             vld1_q, vld1_d;
  logic [2:0]       sec1_q, sec1_d;
  logic [7:0]       fs1_q, fs1_d;
  logic [7:0]       sat1_q, sat1_d;
  logic [7:0]       v1_q, v1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  // Bank 2: products; b and c are kept pre-shifted by 8
  logic             vld2_q, vld2_d;
  logic [2:0]       sec2_q, sec2_d;
  logic [15:0]      a2_q, a2_d;
  logic [15:0]      bh2_q, bh2_d;
  logic [15:0]      ch2_q, ch2_d;
  logic [7:0]       v2_q, v2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;

  // Bank 3: p, q, t channel levels
  logic             vld3_q, vld3_d;
  logic [2:0]       sec3_q, sec3_d;
  logic [7:0]       p3_q, p3_d;
  logic [7:0]       q3_q, q3_d;
  logic [7:0]       t3_q, t3_d;
  logic [7:0]       v3_q, v3_d;
  logic [TAG_W-1:0] tag3_q, tag3_d;

  // Output bank
  logic             out_vld_q, out_vld_d;
  logic [7:0]       r_q, r_d;
  logic [7:0]       g_q, g_d;
  logic [7:0]       b_q, b_d;
  logic [TAG_W-1:0] tag_out_q, tag_out_d;

  logic        en;
  logic [8:0]  h_norm;
  logic [8:0]  f9;
  logic [2:0]  sec_n;
  logic [15:0] s_fs;
  logic [15:0] s_fs_c;

  // Exact floor(x/255) for x <= 65025.
  function automatic logic [7:0] div255(input logic [15:0] x);
    logic [15:0] sum;
    sum = x + 16'd1 + {8'd0, x[15:8]};
    return 8'(sum >> 8);
  endfunction

  assign en        = !out_vld_q || OUT_READY;
  assign IN_READY  = en;
  assign OUT_VALID = out_vld_q;
  assign R_OUT     = r_q;
  assign G_OUT     = g_q;
  assign B_OUT     = b_q;
  assign TAG_OUT   = tag_out_q;

  // Hue normalisation and sector split.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    h_norm = h0_q;
    sec_n  = 3'd0;
    f9     = 9'd0;
    if (h0_q >= 9'd360) h_norm = HUE_WRAP ? (h0_q - 9'd360) : 9'd359;
    if (h_norm < 9'd60) begin
      sec_n = 3'd0; f9 = h_norm;
    end else if (h_norm < 9'd120) begin
      sec_n = 3'd1; f9 = h_norm - 9'd60;
    end else if (h_norm < 9'd180) begin
      sec_n = 3'd2; f9 = h_norm - 9'd120;
    end else if (h_norm < 9'd240) begin
      sec_n = 3'd3; f9 = h_norm - 9'd180;
    end else if (h_norm < 9'd300) begin
      sec_n = 3'd4; f9 = h_norm - 9'd240;
    end else begin
      sec_n = 3'd5; f9 = h_norm - 9'd300;
    end
  end

  assign s_fs   = 16'(sat1_q) * 16'(fs1_q);
  assign s_fs_c = 16'(sat1_q) * (16'd256 - 16'(fs1_q));

  // Next-state for all banks: hold everything on stall, shift everything on en.
  always_comb begin
    vld0_d = vld0_q; h0_d = h0_q; sat0_d = sat0_q; v0_d = v0_q; tag0_d = tag0_q;
    vld1_d = vld1_q; sec1_d = sec1_q; fs1_d = fs1_q; sat1_d = sat1_q;
    v1_d = v1_q; tag1_d = tag1_q;
    vld2_d = vld2_q; sec2_d = sec2_q; a2_d = a2_q; bh2_d = bh2_q; ch2_d = ch2_q;
    v2_d = v2_q; tag2_d = tag2_q;
    vld3_d = vld3_q; sec3_d = sec3_q; p3_d = p3_q; q3_d = q3_q; t3_d = t3_q;
    v3_d = v3_q; tag3_d = tag3_q;
    out_vld_d = out_vld_q; r_d = r_q; g_d = g_q; b_d = b_q; tag_out_d = tag_out_q;

    if (en) begin
      vld0_d = IN_VALID;
      h0_d   = H_IN;
      sat0_d = S_IN;
      v0_d   = V_IN;
      tag0_d = TAG_IN;

      vld1_d = vld0_q;
      sec1_d = sec_n;
      fs1_d  = 8'((15'(f9) * 15'd273) >> 6);
      sat1_d = sat0_q;
      v1_d   = v0_q;
      tag1_d = tag0_q;

      vld2_d = vld1_q;
      sec2_d = sec1_q;
      a2_d   = 16'(v1_q) * 16'(8'd255 - sat1_q);
      bh2_d  = 16'((24'(v1_q) * (24'd65280 - 24'(s_fs))) >> 8);
      ch2_d  = 16'((24'(v1_q) * (24'd65280 - 24'(s_fs_c))) >> 8);
      v2_d   = v1_q;
      tag2_d = tag1_q;

      vld3_d = vld2_q;
      sec3_d = sec2_q;
      p3_d   = div255(a2_q);
      q3_d   = div255(bh2_q);
      t3_d   = div255(ch2_q);
      v3_d   = v2_q;
      tag3_d = tag2_q;

      out_vld_d = vld3_q;
      tag_out_d = tag3_q;
      case (sec3_q)
        3'd1:    begin r_d = q3_q; g_d = v3_q; b_d = p3_q; end
        3'd2:    begin r_d = p3_q; g_d = v3_q; b_d = t3_q; end
        3'd3:    begin r_d = p3_q; g_d = q3_q; b_d = v3_q; end
        3'd4:    begin r_d = t3_q; g_d = p3_q; b_d = v3_q; end
        3'd5:    begin r_d = v3_q; g_d = p3_q; b_d = q3_q; end
        default: begin r_d = v3_q; g_d = t3_q; b_d = p3_q; end
      endcase
    end
  end

  // Control and visible outputs: cleared by reset so in-flight pixels vanish.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld0_q    <= 1'b0;
      vld1_q    <= 1'b0;
      vld2_q    <= 1'b0;
      vld3_q    <= 1'b0;
      out_vld_q <= 1'b0;
      r_q       <= 8'd0;
      g_q       <= 8'd0;
      b_q       <= 8'd0;
      tag_out_q <= '0;
    end else begin
      vld0_q    <= vld0_d;
      vld1_q    <= vld1_d;
      vld2_q    <= vld2_d;
      vld3_q    <= vld3_d;
      out_vld_q <= out_vld_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      tag_out_q <= tag_out_d;
    end
  end

  // NOTE: internal datapath registers carry no reset; their contents are only consumed when the matching valid bit is set.
  always_ff @(posedge CLK) begin
    h0_q   <= h0_d;
    sat0_q <= sat0_d;
    v0_q   <= v0_d;
    tag0_q <= tag0_d;
    sec1_q <= sec1_d;
    fs1_q  <= fs1_d;
    sat1_q <= sat1_d;
    v1_q   <= v1_d;
    tag1_q <= tag1_d;
    sec2_q <= sec2_d;
    a2_q   <= a2_d;
    bh2_q  <= bh2_d;
    ch2_q  <= ch2_d;
    v2_q   <= v2_d;
    tag2_q <= tag2_d;
    sec3_q <= sec3_d;
    p3_q   <= p3_d;
    q3_q   <= q3_d;
    t3_q   <= t3_d;
    v3_q   <= v3_d;
    tag3_q <= tag3_d;
  end

endmodule
